ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends single command bytes to the keyboard, for example 0xED followed by an LED mask, or 0xFF for reset, over the same PS2_CLK/PS2_DATA lines used by keyboard_input. It runs in the fast `clock` domain beside keyboard_input and drives the open-drain lines via output-enables; the top level ties each line to 0 when its enable is high, else 'bz. It produces rx_inhibit so keyboard_input ignores traffic the host itself originates.

Parameters:
CLK_HZ, 100000000, frequency of `clock` in Hz
INHIBIT_US, 100, clock-low inhibit time before request-to-send, in microseconds
TIMEOUT_US, 15000, maximum wait for any device clock edge once the line is released, in microseconds

Ports:
clock  in  1  system clock
resetn  in  1  synchronous reset, active-low
tx_valid  in  1  command byte available
tx_data  in  8  command byte
tx_ready  out  1  high only in IDLE; byte accepted on the cycle where tx_valid && tx_ready
ps2_clk_in  in  1  raw PS2_CLK pin value (asynchronous)
ps2_data_in  in  1  raw PS2_DATA pin value (asynchronous)
ps2_clk_oe  out  1  1 = pull PS2_CLK low
ps2_data_oe  out  1  1 = pull PS2_DATA low
busy  out  1  high in every state except IDLE
rx_inhibit  out  1  equals busy; keyboard_input must discard frames while high
done  out  1  one-cycle pulse: frame acknowledged and bus idle
ack_error  out  1  one-cycle pulse: ack bit was 1, or a timeout occurred

Behaviour:
- Reset: when resetn=0 at a clock edge, the block goes to IDLE. Outputs: tx_ready=1, ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, ack_error=0. Counters and shift register clear. Reset mid-frame releases both lines on the next cycle with no done or ack_error pulse.
- Input synchronizers: ps2_clk_in and ps2_data_in each pass through 2 flops. A falling edge is prev_sync=1 and sync=0. All edge detection uses the synced values, so a 3-cycle latency from the pin is allowed.
- Frame: 11 bits. Start bit 0, tx_data[0..7] LSB first, odd parity (parity = ~^tx_data), stop bit 1, then the device's ack.
- States and transitions:
  - IDLE: tx_ready=1. On accept, latch tx_data, compute parity → INHIBIT.
  - INHIBIT: clk_oe=1 for INHIBIT_US*CLK_HZ/1e6 cycles (counter), then → RTS.
  - RTS: clk_oe=1, data_oe=1 (start bit) for exactly 1 cycle → RELEASE.
  - RELEASE: clk_oe=0, data_oe held at 1; bit counter=0 → SEND.
  - SEND: on each synced clk falling edge, present the next bit with data_oe=~bit. Edges 1–8 present d0–d7, edge 9 presents parity, edge 10 presents the stop bit (data_oe=0). After edge 10 → ACK.
  - ACK: on the next falling edge, sample synced data. 0 → WAIT_IDLE. 1 → ERR.
  - WAIT_IDLE: wait until synced clk=1 and synced data=1 → DONE.
  - DONE: done=1 for 1 cycle → IDLE.
  - ERR: ack_error=1 for 1 cycle, both oe=0 → IDLE.
- Data changes only while the device clock is low; the device samples on the rising edge.
- tx_valid while busy is ignored, because tx_ready=0; the upstream keeps it asserted. Back-to-back commands: the next accept can occur on the cycle after DONE.
- Spurious clk edges in IDLE are ignored.

Optional Feature:
- Macro: PS2_HOST_TX_TIMEOUT_EN.
- When defined: in RELEASE, SEND, ACK and WAIT_IDLE, a counter reloads on every synced clk edge (rise or fall). If it reaches TIMEOUT_US*CLK_HZ/1e6 cycles, the block releases both lines and goes to ERR (ack_error pulse).
- When undefined: there is no timeout counter, and the block waits indefinitely for the device.

Test Plan (CLK_HZ=1000000, so INHIBIT=100 cycles and TIMEOUT=15000 cycles; device model clocks at a 40 µs period):
- Send 0xED, device acks 0 → clk_oe low for exactly 100 cycles. Data bits observed at device rising edges: 0, 1,0,1,1,0,1,1,1, parity 1, stop 1. Then one done pulse, no ack_error, tx_ready returns to 1.
- Send 0x01 → parity bit 0. Send 0x00 → parity bit 1. Send 0xFF → parity bit 1. All three are acked, giving 3 done pulses.
- Device returns ack=1 for 0xF4 → ack_error pulse, no done, both oe=0, back in IDLE.
- With the macro defined, the device never clocks after RELEASE → ack_error exactly 15000 cycles (±3) after RELEASE, lines released. With the macro undefined → busy stays 1.
- resetn=0 for one cycle after the 4th data edge → next cycle both oe=0, busy=0, no pulses. A fresh 0xED afterwards completes correctly.
- tx_valid held during an entire frame with the data changing → only the first byte is sent; the second byte is accepted on the cycle after done.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ============================================================================
//  Module      : ps2_host_tx
//  Description : PS/2 host-to-device command transmitter. Inhibits the bus,
//                issues request-to-send, shifts out start/data/parity/stop on
//                device clock falling edges and checks the device ack bit.
//                Drives the open-drain lines through output enables.
//  Options     : define PS2_HOST_TX_TIMEOUT_EN to abort a frame when the
//                device stops clocking for TIMEOUT_US.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_host_tx #(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned TIMEOUT_US = 15000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       rx_inhibit,
  output logic       done,
  output logic       ack_error
);

  // Cycle counts are computed in 64 bits: INHIBIT_US * CLK_HZ overflows 32.
  localparam logic [63:0] C_INH_64  = (64'(INHIBIT_US) * 64'(CLK_HZ)) / 64'd1000000;
  localparam int unsigned C_INH_CYC = (C_INH_64 == 64'd0) ? 32'd1 : C_INH_64[31:0];
  localparam int          C_INH_W   = $clog2(C_INH_CYC + 1);
  localparam logic [C_INH_W-1:0] C_INH_LAST = C_INH_W'(C_INH_CYC - 1);

  // A zero-length inhibit or timeout is not a usable configuration.
  if (INHIBIT_US == 0 || TIMEOUT_US == 0) begin : g_cfg_check
    $error("ps2_host_tx: INHIBIT_US and TIMEOUT_US must be non-zero");
  end

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_INHIBIT   = 4'd1,
    S_RTS       = 4'd2,
    S_RELEASE   = 4'd3,
    S_SEND      = 4'd4,
    S_ACK       = 4'd5,
    S_WAIT_IDLE = 4'd6,
    S_DONE      = 4'd7,
    S_ERR       = 4'd8
  } state_t;

  state_t               state_q;
  logic                 tx_ready_q;
  logic                 clk_oe_q;
  logic                 data_oe_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic [C_INH_W-1:0]   inh_cnt_q;
  logic [3:0]           bit_cnt_q;
  logic [7:0]           shift_q;
  logic                 parity_q;

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;

  logic w_clk_fall;

  // Two-flop synchronizers on the raw pins plus one delayed clock copy for
  // edge detection; everything idles high like the released bus.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_in;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_in;
      data_sync_q <= data_meta_q;
    end
  end

  assign w_clk_fall = clk_prev_q & ~clk_sync_q;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam logic [63:0] C_TMO_64  = (64'(TIMEOUT_US) * 64'(CLK_HZ)) / 64'd1000000;
  localparam int unsigned C_TMO_CYC = (C_TMO_64 == 64'd0) ? 32'd1 : C_TMO_64[31:0];
  localparam int          C_TMO_W   = $clog2(C_TMO_CYC + 1);
  localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(C_TMO_CYC - 1);

  logic [C_TMO_W-1:0] tmo_cnt_q;
  logic               w_clk_edge;
  logic               w_timed;

  assign w_clk_edge = clk_prev_q ^ clk_sync_q;
  assign w_timed    = (state_q == S_RELEASE) || (state_q == S_SEND) ||
                      (state_q == S_ACK)     || (state_q == S_WAIT_IDLE);
`endif

  // Frame sequencer; every output is registered and set on entry to the
  // state it belongs to, so outputs line up exactly with the state.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      tx_ready_q <= 1'b1;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      inh_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // Clock edges seen here are device traffic or noise: ignored.
          if (tx_valid && tx_ready_q) begin
            shift_q    <= tx_data;
            parity_q   <= ~^tx_data;
            inh_cnt_q  <= '0;
            clk_oe_q   <= 1'b1;
            data_oe_q  <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (inh_cnt_q == C_INH_LAST) begin
            data_oe_q <= 1'b1;           // start bit, clock still held
            state_q   <= S_RTS;
          end else begin
            inh_cnt_q <= inh_cnt_q + 1'b1;
          end
        end

        S_RTS: begin
          clk_oe_q  <= 1'b0;             // hand the clock to the device
          bit_cnt_q <= '0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
          state_q   <= S_RELEASE;
        end

        S_RELEASE: begin
          state_q <= S_SEND;
        end

        S_SEND: begin
          // Data only changes while the device holds its clock low.
          if (w_clk_fall) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q < 4'd8) begin
              data_oe_q <= ~shift_q[bit_cnt_q[2:0]];
            end else if (bit_cnt_q == 4'd8) begin
              data_oe_q <= ~parity_q;
            end else begin
              data_oe_q <= 1'b0;         // stop bit, line released
              state_q   <= S_ACK;
            end
          end
        end

        S_ACK: begin
          if (w_clk_fall) begin
            if (!data_sync_q) begin
              state_q <= S_WAIT_IDLE;
            end else begin
              clk_oe_q  <= 1'b0;
              data_oe_q <= 1'b0;
              err_q     <= 1'b1;
              state_q   <= S_ERR;
            end
          end
        end

        S_WAIT_IDLE: begin
          if (clk_sync_q && data_sync_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end

        S_DONE, S_ERR: begin
          tx_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end

        default: begin
          clk_oe_q   <= 1'b0;
          data_oe_q  <= 1'b0;
          tx_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
      // Any device clock edge restarts the watchdog; a silent device for the
      // whole window aborts the frame. Overrides whatever the case chose.
      if (w_timed) begin
        if (w_clk_edge) begin
          tmo_cnt_q <= '0;
        end else if (tmo_cnt_q == C_TMO_LAST) begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          done_q    <= 1'b0;
          err_q     <= 1'b1;
          state_q   <= S_ERR;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
      end
`endif
    end
  end

  assign tx_ready    = tx_ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign rx_inhibit  = busy_q;
  assign done        = done_q;
  assign ack_error   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// ============================================================================
//  Module      : tb_ps2_host_tx
//  Description : Self-checking bench for ps2_host_tx with a PS/2 device model
//                (40-cycle clock period at CLK_HZ = 1 MHz).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_host_tx;

  localparam int INH_CYC = 100;
  localparam int TMO_CYC = 15000;
  localparam int HALF    = 20;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, rx_inhibit, done, ack_error;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  wire        ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  wire        ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_HZ     (1000000),
    .INHIBIT_US (100),
    .TIMEOUT_US (15000)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .rx_inhibit  (rx_inhibit),
    .done        (done),
    .ack_error   (ack_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         exp_done;
    bit         exp_err;
    bit         exp_par;
  } vec_t;

  typedef struct {
    bit d;
    bit e;
  } res_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   done_cyc = -1;
  int   acc_cnt = 0;
  int   acc_cyc = -1;
  bit   exp_bits[$];
  res_t res_q[$];
  vec_t vecs[5];

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (ack_error === 1'b1) err_cnt++;
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin acc_cnt++; acc_cyc = cyc; end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit odd_par(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return (n % 2) == 0;
  endfunction

  task automatic push_frame(input logic [7:0] d, input bit par);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    exp_bits.push_back(par);
    exp_bits.push_back(1'b1);
  endtask

  task automatic start_tx(input logic [7:0] d, input bit par, input bit hold);
    int n;
    n = 0;
    @(negedge clock);
    tx_valid = 1'b1;
    tx_data  = d;
    push_frame(d, par);
    while (tx_ready !== 1'b1 && n < 500) begin @(negedge clock); n++; end
    chk("accept_wait", 32'(n < 500), 1);
    @(posedge clock);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic measure_inhibit();
    int n;
    n = 0;
    @(negedge clock);
    while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && n < 1000) begin
      n++;
      @(negedge clock);
    end
    chk("inhibit_cycles", n, INH_CYC);
    chk("rts_lines", {ps2_clk_oe, ps2_data_oe}, 2'b11);
    @(negedge clock);
    chk("release_lines", {ps2_clk_oe, ps2_data_oe}, 2'b01);
  endtask

  task automatic dev_sample(input string name);
    if (exp_bits.size() == 0) begin
      chk({name, "_unexpected"}, 1, 0);
    end else begin
      chk(name, ps2_data_in, exp_bits.pop_front());
    end
  endtask

  // Device model: samples on its rising clock edges, ack driven before the
  // 11th falling edge. stop_after<0 runs a full frame, 0 never clocks.
  task automatic serve(input bit ack, input int stop_after);
    int n;
    n = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 1000) begin
      @(negedge clock);
      n++;
    end
    chk("release_seen", 32'(n < 1000), 1);
    if (stop_after == 0) return;
    repeat (HALF) @(negedge clock);
    dev_sample("start_bit");
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clock);
      dev_clk_low = 1'b0;
      dev_sample($sformatf("frame_bit%0d", i));
      if (i == stop_after) return;
      repeat (HALF - 1) @(negedge clock);
    end
    if (!ack) dev_data_low = 1'b1;
    repeat (10) @(negedge clock);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clock);
    dev_clk_low = 1'b0;
    repeat (10) @(negedge clock);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_result(input int d0, input int e0, input bit check_idle);
    int   n;
    res_t r;
    n = 0;
    while ((done_cnt + err_cnt) == (d0 + e0) && n < 400) begin @(negedge clock); n++; end
    chk("result_seen", 32'(n < 400), 1);
    repeat (3) @(negedge clock);
    if (res_q.size() == 0) begin
      chk("result_unexpected", 1, 0);
    end else begin
      r = res_q.pop_front();
      chk("done_pulses", done_cnt - d0, 32'(r.d));
      chk("ack_error_pulses", err_cnt - e0, 32'(r.e));
    end
    if (check_idle) begin
      chk("idle_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      chk("idle_ready", {tx_ready, busy, rx_inhibit}, 3'b100);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, a1, n, dref, eref;
    logic [7:0] b;

    vecs[0] = '{8'hED, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'hF4, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset state
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("rst_busy", {busy, rx_inhibit}, 2'b00);
    chk("rst_pulses", {done, ack_error}, 2'b00);
    resetn = 1'b1;

    // Spurious device clock pulses in IDLE
    repeat (3) begin
      repeat (5) @(negedge clock);
      dev_clk_low = 1'b1;
      repeat (5) @(negedge clock);
      dev_clk_low = 1'b0;
    end
    repeat (5) @(negedge clock);
    chk("spurious_idle", {tx_ready, busy, ps2_clk_oe, ps2_data_oe}, 4'b1000);

    // Table-driven frames
    for (int k = 0; k < 5; k++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      res_q.push_back('{vecs[k].exp_done, vecs[k].exp_err});
      start_tx(vecs[k].data, vecs[k].exp_par, 1'b0);
      measure_inhibit();
      serve(vecs[k].ack, -1);
      wait_result(d0, e0, 1'b1);
    end

    // Reset after the 4th data edge
    start_tx(8'h5A, odd_par(8'h5A), 1'b0);
    serve(1'b0, 4);
    dref = done_cnt;
    eref = err_cnt;
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    chk("midrst_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("midrst_busy", {busy, tx_ready}, 2'b01);
    resetn = 1'b1;
    exp_bits.delete();
    repeat (20) @(negedge clock);
    chk("midrst_no_pulse", (done_cnt - dref) + (err_cnt - eref), 0);

    d0 = done_cnt;
    e0 = err_cnt;
    res_q.push_back('{1'b1, 1'b0});
    start_tx(8'hED, 1'b1, 1'b0);
    measure_inhibit();
    serve(1'b0, -1);
    wait_result(d0, e0, 1'b1);

    // tx_valid held through a frame while the data changes
    d0 = done_cnt;
    e0 = err_cnt;
    res_q.push_back('{1'b1, 1'b0});
    start_tx(8'h12, odd_par(8'h12), 1'b1);
    a1 = acc_cnt;
    tx_data = 8'h34;
    push_frame(8'h34, odd_par(8'h34));
    serve(1'b0, -1);
    wait_result(d0, e0, 1'b0);
    n = 0;
    while (acc_cnt == a1 && n < 500) begin @(negedge clock); n++; end
    chk("second_accept_seen", 32'(n < 500), 1);
    chk("accept_after_done", acc_cyc, done_cyc + 1);
    @(posedge clock);
    #1;
    tx_valid = 1'b0;
    d0 = done_cnt;
    e0 = err_cnt;
    res_q.push_back('{1'b1, 1'b0});
    serve(1'b0, -1);
    wait_result(d0, e0, 1'b1);

    // Device goes silent after release
    start_tx(8'hF0, odd_par(8'hF0), 1'b0);
    measure_inhibit();
    eref = err_cnt;
    serve(1'b0, 0);
    exp_bits.delete();
`ifdef PS2_HOST_TX_TIMEOUT_EN
    n = 0;
    while (ack_error !== 1'b1 && n < TMO_CYC + 1000) begin @(negedge clock); n++; end
    chk("timeout_window", 32'(n >= TMO_CYC - 3 && n <= TMO_CYC + 3), 1);
    chk("timeout_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    @(negedge clock);
    chk("timeout_idle", {tx_ready, busy}, 2'b10);
    chk("timeout_err_pulse", err_cnt - eref, 1);
`else
    repeat (1000) @(negedge clock);
    chk("no_timeout_busy", {busy, rx_inhibit, tx_ready}, 3'b110);
    chk("no_timeout_no_err", err_cnt - eref, 0);
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("final_idle", {tx_ready, busy, ps2_clk_oe, ps2_data_oe}, 4'b1000);
`endif

    b = 8'h00;
    chk("scoreboard_empty", exp_bits.size() + res_q.size() + int'(b), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
